// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Brief    : Start/busy/done operand and result bundle for serial_subtractor.
// Revision : 1.0
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Diff;
    logic             B_out;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B,
        input  Diff, B_out, busy, done
    );

    modport slave (
        input  start, A, B,
        output Diff, B_out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial unsigned subtractor, Diff = A - B, LSB first, one
//            full-subtractor slice per clock with a single borrow flop.
// Revision : 1.0
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input wire logic          clk,
    input wire logic          rst,
    serial_subtractor_if.slave bus
);

    localparam int c_cnt_w = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_d_sr;
    logic               r_borrow;
    logic [c_cnt_w-1:0] r_cnt;

    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_busy;
    logic               r_done;

    logic               w_a;
    logic               w_b;
    logic               w_d;
    logic               w_borrow_next;
    logic [WIDTH-1:0]   w_d_shifted;
    logic               w_capture;
    logic               w_last;

    // Single full-subtractor slice operating on the current LSBs.
    assign w_a           = r_a_sr[0];
    assign w_b           = r_b_sr[0];
    assign w_d           = w_a ^ w_b ^ r_borrow;
    assign w_borrow_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    assign w_d_shifted   = {w_d, r_d_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt == c_last) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // The edge closing the done cycle is the earliest point a new
                // request is taken, giving a WIDTH+1 cycle back-to-back period.
                if (bus.start) begin
                    w_capture    = 1'b1;
                    w_state_next = S_SHIFT;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (w_capture) begin
            r_a_sr   <= bus.A;
            r_b_sr   <= bus.B;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_state == S_SHIFT) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_d_sr   <= w_d_shifted;
            r_borrow <= w_borrow_next;
            r_cnt    <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
                r_diff <= w_d_shifted;
                r_bout <= w_borrow_next;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else if (r_state == S_DONE) begin
            r_done <= 1'b0;
        end
    end

    assign bus.Diff  = r_diff;
    assign bus.B_out = r_bout;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=4.
// Revision : 1.0
// ============================================================================
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst8;
    logic rst4;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8.slave)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (if4.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: last completed result per instance (index 0 = W8).
    int m_diff [2];
    int m_bout [2];

    function automatic int idx(input int w);
        return (w == 8) ? 0 : 1;
    endfunction

    function automatic int ref_diff(input int w, input int a, input int b);
        return (a - b) & ((1 << w) - 1);
    endfunction

    function automatic int ref_borrow(input int a, input int b);
        return (a < b) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic s, input int a, input int b);
        if (w == 8) begin
            if8.start = s;
            if8.A     = 8'(a);
            if8.B     = 8'(b);
        end else begin
            if4.start = s;
            if4.A     = 4'(a);
            if4.B     = 4'(b);
        end
    endtask

    task automatic sample(input int w, output int busy, output int done,
                          output int bout, output int diff);
        if (w == 8) begin
            busy = int'(if8.busy);
            done = int'(if8.done);
            bout = int'(if8.B_out);
            diff = int'(if8.Diff);
        end else begin
            busy = int'(if4.busy);
            done = int'(if4.done);
            bout = int'(if4.B_out);
            diff = int'(if4.Diff);
        end
    endtask

    // Checks busy/done/result against the model's expectation for this cycle.
    task automatic expect_state(input int w, input string tag,
                                input int busy_e, input int done_e);
        int busy, done, bout, diff;
        sample(w, busy, done, bout, diff);
        check({tag, ".busy"}, busy, busy_e);
        check({tag, ".done"}, done, done_e);
        check({tag, ".diff"}, diff, m_diff[idx(w)]);
        check({tag, ".bout"}, bout, m_bout[idx(w)]);
    endtask

    task automatic run_op(input int w, input int a, input int b, input string tag);
        drive(w, 1'b1, a, b);
        tick();                                   // edge 0
        drive(w, 1'b0, int'($urandom), int'($urandom));
        expect_state(w, {tag, ".e0"}, 1, 0);
        for (int k = 1; k < w; k++) begin
            tick();
            drive(w, 1'b0, int'($urandom), int'($urandom));
            expect_state(w, {tag, ".shift"}, 1, 0);
        end
        tick();                                   // edge WIDTH
        m_diff[idx(w)] = ref_diff(w, a, b);
        m_bout[idx(w)] = ref_borrow(a, b);
        expect_state(w, {tag, ".done"}, 0, 1);
        tick();                                   // edge WIDTH+1
        expect_state(w, {tag, ".after"}, 0, 0);
    endtask

    initial begin
        int a0, b0, a1, b1;

        m_diff = '{0, 0};
        m_bout = '{0, 0};
        rst8 = 1'b1;
        rst4 = 1'b1;
        drive(8, 1'b0, 0, 0);
        drive(4, 1'b0, 0, 0);
        tick();
        tick();
        expect_state(8, "reset8", 0, 0);
        expect_state(4, "reset4", 0, 0);
        rst8 = 1'b0;
        rst4 = 1'b0;
        tick();

        // Directed cases with idle hold afterwards.
        run_op(8, 8'h5A, 8'h3C, "op5A_3C");
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_state(8, "idle_hold", 0, 0);
        end
        run_op(8, 8'h00, 8'h01, "op00_01");
        run_op(8, 8'hA5, 8'hA5, "opA5_A5");

        // Continuous start with operands churning during SHIFT.
        a0 = int'($urandom_range(255));
        b0 = int'($urandom_range(255));
        drive(8, 1'b1, a0, b0);
        tick();                                   // edge 0
        expect_state(8, "b2b.e0", 1, 0);
        for (int k = 1; k < 8; k++) begin
            drive(8, 1'b1, int'($urandom), int'($urandom));
            tick();
            expect_state(8, "b2b.shift1", 1, 0);
        end
        drive(8, 1'b1, int'($urandom), int'($urandom));
        tick();                                   // edge 8
        m_diff[0] = ref_diff(8, a0, b0);
        m_bout[0] = ref_borrow(a0, b0);
        expect_state(8, "b2b.done1", 0, 1);
        a1 = int'($urandom_range(255));
        b1 = int'($urandom_range(255));
        drive(8, 1'b1, a1, b1);
        tick();                                   // edge 9: second accept
        expect_state(8, "b2b.accept2", 1, 0);
        for (int k = 1; k < 8; k++) begin
            drive(8, 1'b1, int'($urandom), int'($urandom));
            tick();
            expect_state(8, "b2b.shift2", 1, 0);
        end
        drive(8, 1'b0, int'($urandom), int'($urandom));
        tick();                                   // edge 17
        m_diff[0] = ref_diff(8, a1, b1);
        m_bout[0] = ref_borrow(a1, b1);
        expect_state(8, "b2b.done2", 0, 1);
        tick();
        expect_state(8, "b2b.after", 0, 0);

        // Reset in the middle of an operation.
        drive(8, 1'b1, 8'hF0, 8'h0F);
        tick();                                   // edge 0
        drive(8, 1'b0, 0, 0);
        for (int k = 1; k <= 4; k++) tick();      // edge 4
        rst8 = 1'b1;
        #1;
        m_diff[0] = 0;
        m_bout[0] = 0;
        expect_state(8, "midrst.imm", 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            expect_state(8, "midrst.hold", 0, 0);
        end
        rst8 = 1'b0;
        tick();
        expect_state(8, "midrst.release", 0, 0);
        run_op(8, 8'hF0, 8'h0F, "opF0_0F");

        // Random operands on the 8-bit instance.
        for (int i = 0; i < 8; i++) begin
            run_op(8, int'($urandom_range(255)), int'($urandom_range(255)), "rand8");
        end

        // Exhaustive sweep on the 4-bit instance.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4, a, b, "exh4");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
